i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter START_HOLD, default 64: sys_clk cycles i2c_start is held high; must be at least one i2c_clk period.
REQ-002 Parameter WR_CYCLE, default 250_000: post-write EEPROM busy wait in sys_clk cycles (5 ms at 50 MHz).
REQ-003 Parameter TIMEOUT, default 2_000_000: maximum cycles from first i2c_start high to i2c_end rise.
REQ-004 Parameter ADDR_NUM, default 1'b1: 1 selects 2-byte word address, 0 selects 1-byte.
REQ-005 sys_clk  in  1  system clock; sole clock for the block.
REQ-006 sys_rst_n  in  1  reset; synchronous, active-low.
REQ-007 req0_valid, req1_valid  in  1 each  requester transaction request; held high until matching done.
REQ-008 req0_wr, req1_wr  in  1 each  1 = write, 0 = read.
REQ-009 req0_addr, req1_addr  in  16 each  byte address.
REQ-010 req0_wdata, req1_wdata  in  8 each  write data.
REQ-011 req0_done, req1_done  out  1 each  one-cycle completion pulse.
REQ-012 rd_data  out  8  read result, valid from the done pulse until the next done.
REQ-013 err  out  1  one-cycle pulse, coincident with done, on timeout.
REQ-014 wr_en, rd_en, i2c_start, addr_num  out  1 each  controls to i2c controller.
REQ-015 byte_addr  out  16  word address to i2c controller.
REQ-016 i2c_write_data  out  8  write byte to i2c controller.
REQ-017 i2c_end  in  1  controller completion; a level pulse lasting several sys_clk cycles.
REQ-018 i2c_read_data  in  8  controller read byte; valid when i2c_end rises.

Function
REQ-019 FSM states: IDLE, START, WAIT_END, WR_WAIT.
- REQ-020 IDLE: when any reqN_valid is high, latch the grant, wr flag, addr and wdata; drive wr_en=wr, rd_en=~wr, byte_addr and i2c_write_data; go to START.
- REQ-021 START: drive i2c_start=1 for exactly START_HOLD cycles, then go to WAIT_END.
- REQ-022 WAIT_END: on an i2c_end rising edge (i2c_end=1 with registered previous value 0), do the following in the same transition:
  - pulse the granted reqN_done;
  - if a read, load rd_data from i2c_read_data;
  - if a write, go to WR_WAIT; otherwise go to IDLE.
- REQ-023 WR_WAIT: count WR_CYCLE cycles, then go to IDLE; no new grant is issued during WR_WAIT.
REQ-024 Round-robin: a last_grant register selects the winner when both requests are valid; the requester not last granted wins; last_grant updates on each grant.
REQ-025 Single valid request: that requester is granted regardless of last_grant.
REQ-026 Latency: IDLE with valid -> i2c_start high on the next cycle.
REQ-027 wr_en, rd_en, byte_addr and i2c_write_data stay stable from grant until leaving WAIT_END.
REQ-028 After leaving WAIT_END, wr_en and rd_en return to 0.
REQ-029 addr_num is constant ADDR_NUM.
REQ-030 reqN_valid deasserting after grant is ignored; the transaction completes and done still pulses.
REQ-031 Timeout: a watchdog counter runs in START and WAIT_END. On reaching TIMEOUT:
  - pulse done and err together;
  - leave rd_data unchanged;
  - go to IDLE, skipping WR_WAIT.
REQ-032 An i2c_end level that is already high when WAIT_END is entered does not count as completion; only a fresh rising edge counts.
REQ-033 A new grant requires IDLE; the earliest new grant is the cycle after returning to IDLE, so back-to-back requests are separated by at least one IDLE cycle.

Reset
REQ-034 While sys_rst_n=0 at a sys_clk edge, the block resets as follows:
  - state=IDLE, last_grant=1 (req0 wins first);
  - all done/err/wr_en/rd_en/i2c_start=0, byte_addr=0, i2c_write_data=0, rd_data=0, counters=0.
REQ-035 Reset mid-transaction aborts it immediately with no done pulse; outputs take their reset values at the first reset edge.

Verification
REQ-036 req0 write, addr 16'h0010, data 8'hA5 -> outputs and sequence:
  - wr_en=1, byte_addr=16'h0010, i2c_write_data=8'hA5;
  - i2c_start high 64 cycles;
  - i2c_end pulse -> req0_done one cycle;
  - no new grant for 250_000 cycles.
REQ-037 req1 read, addr 16'h0123, model returns 8'h3C -> rd_en=1; req1_done pulse with rd_data=8'h3C; IDLE on the next cycle.
REQ-038 Both valid out of reset -> req0 granted first, req1 granted second; both valid again -> req0 granted (alternation).
REQ-039 Read with i2c_end never asserted -> req0_done and err pulse together at TIMEOUT; rd_data unchanged; back in IDLE.
REQ-040 sys_rst_n low during WAIT_END -> no done pulse; all outputs 0; a subsequent request is served normally.
REQ-041 i2c_end held high across the START->WAIT_END boundary, then low, then high -> done only on the second rising edge.

Source files
------------

// File: rtl/i2c_arbiter.sv
// i2c_arbiter
//   Shares one I2C EEPROM controller between two requesters. A requester is
//   granted in IDLE (round-robin when both ask), the controller is started by
//   holding i2c_start high for START_HOLD cycles, and completion is taken from
//   a fresh rising edge of i2c_end. Writes are followed by a WR_CYCLE busy wait
//   so the EEPROM can finish its internal program cycle. A watchdog aborts a
//   transaction that does not complete within TIMEOUT cycles.
//
// Ports
//   sys_clk, sys_rst_n            clock, synchronous active-low reset
//   reqN_valid/wr/addr/wdata      requester N transaction (held until reqN_done)
//   reqN_done                     one-cycle completion pulse to requester N
//   rd_data                       read result, valid from done until next done
//   err                           one-cycle pulse with done on watchdog expiry
//   wr_en, rd_en, i2c_start       controls to the I2C controller
//   addr_num                      word-address size select (constant ADDR_NUM)
//   byte_addr, i2c_write_data     address / write byte to the I2C controller
//   i2c_end, i2c_read_data        controller completion level and read byte
module i2c_arbiter #(
  parameter int   START_HOLD = 64,
  parameter int   WR_CYCLE   = 250_000,
  parameter int   TIMEOUT    = 2_000_000,
  parameter logic ADDR_NUM   = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_wr,
  input  logic        req1_wr,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req0_wdata,
  input  logic [7:0]  req1_wdata,
  output logic        req0_done,
  output logic        req1_done,
  output logic [7:0]  rd_data,
  output logic        err,
  output logic        wr_en,
  output logic        rd_en,
  output logic        i2c_start,
  output logic        addr_num,
  output logic [15:0] byte_addr,
  output logic [7:0]  i2c_write_data,
  input  logic        i2c_end,
  input  logic [7:0]  i2c_read_data
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_WR_WAIT  = 2'd3
  } state_t;

  localparam logic [31:0] HOLD_LAST = 32'(START_HOLD - 1);
  localparam logic [31:0] WR_LAST   = 32'(WR_CYCLE - 1);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);

  state_t      state_r, state_s;
  logic        last_grant_r, last_grant_s;
  logic        grant_r, grant_s;
  logic        pick_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] wdog_r, wdog_s;
  logic        end_d_r;
  logic        end_rise_s;
  logic        finish_s;
  logic        err_s, wr_en_s, rd_en_s, i2c_start_s;
  logic        req0_done_s, req1_done_s;
  logic [15:0] byte_addr_s;
  logic [7:0]  wdata_s, rd_data_s;

  assign addr_num   = ADDR_NUM;
  // Completion needs a fresh edge; a level already high on entry is ignored.
  assign end_rise_s = i2c_end & ~end_d_r;

  // Winner selection: with both valid the requester not granted last time wins.
  always_comb begin
    if (req0_valid && req1_valid) begin
      pick_s = ~last_grant_r;
    end else begin
      pick_s = req1_valid;
    end
  end

  // Next-state and next-output logic of the transaction FSM.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    grant_s      = grant_r;
    cnt_s        = cnt_r;
    wdog_s       = wdog_r;
    finish_s     = 1'b0;
    err_s        = 1'b0;
    rd_data_s    = rd_data;
    wr_en_s      = wr_en;
    rd_en_s      = rd_en;
    i2c_start_s  = i2c_start;
    byte_addr_s  = byte_addr;
    wdata_s      = i2c_write_data;
    case (state_r)
      ST_IDLE: begin
        cnt_s  = 32'd0;
        wdog_s = 32'd0;
        if (req0_valid || req1_valid) begin
          grant_s      = pick_s;
          last_grant_s = pick_s;
          wr_en_s      = pick_s ? req1_wr : req0_wr;
          rd_en_s      = pick_s ? ~req1_wr : ~req0_wr;
          byte_addr_s  = pick_s ? req1_addr : req0_addr;
          wdata_s      = pick_s ? req1_wdata : req0_wdata;
          i2c_start_s  = 1'b1;
          state_s      = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        wdog_s = wdog_r + 32'd1;
        if (wdog_r == TO_LAST) begin
          finish_s = 1'b1;
          err_s    = 1'b1;
        end else if (cnt_r == HOLD_LAST) begin
          cnt_s       = 32'd0;
          i2c_start_s = 1'b0;
          state_s     = ST_WAIT_END;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      ST_WAIT_END: begin
        wdog_s = wdog_r + 32'd1;
        if (end_rise_s) begin
          finish_s = 1'b1;
          if (!wr_en) begin
            rd_data_s = i2c_read_data;
          end else begin
            rd_data_s = rd_data;
          end
        end else if (wdog_r == TO_LAST) begin
          finish_s = 1'b1;
          err_s    = 1'b1;
        end else begin
          state_s = ST_WAIT_END;
        end
      end
      ST_WR_WAIT: begin
        if (cnt_r == WR_LAST) begin
          cnt_s   = 32'd0;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + 32'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Common wind-down for completion and timeout; only a clean write
    // completion enters the EEPROM busy wait.
    if (finish_s) begin
      wr_en_s     = 1'b0;
      rd_en_s     = 1'b0;
      i2c_start_s = 1'b0;
      cnt_s       = 32'd0;
      wdog_s      = 32'd0;
      state_s     = (wr_en && !err_s) ? ST_WR_WAIT : ST_IDLE;
    end else begin
      wr_en_s = wr_en_s;
    end
    req0_done_s = finish_s & ~grant_r;
    req1_done_s = finish_s & grant_r;
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r        <= ST_IDLE;
      last_grant_r   <= 1'b1;
      grant_r        <= 1'b0;
      cnt_r          <= 32'd0;
      wdog_r         <= 32'd0;
      end_d_r        <= 1'b0;
      req0_done      <= 1'b0;
      req1_done      <= 1'b0;
      err            <= 1'b0;
      rd_data        <= 8'h00;
      wr_en          <= 1'b0;
      rd_en          <= 1'b0;
      i2c_start      <= 1'b0;
      byte_addr      <= 16'h0000;
      i2c_write_data <= 8'h00;
    end else begin
      state_r        <= state_s;
      last_grant_r   <= last_grant_s;
      grant_r        <= grant_s;
      cnt_r          <= cnt_s;
      wdog_r         <= wdog_s;
      end_d_r        <= i2c_end;
      req0_done      <= req0_done_s;
      req1_done      <= req1_done_s;
      err            <= err_s;
      rd_data        <= rd_data_s;
      wr_en          <= wr_en_s;
      rd_en          <= rd_en_s;
      i2c_start      <= i2c_start_s;
      byte_addr      <= byte_addr_s;
      i2c_write_data <= wdata_s;
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: self-checking bench for i2c_arbiter. A reference model of
// the arbitration and timing rules predicts grant, controls, read data and
// cycle counts for directed and randomized transactions.
module tb_i2c_arbiter;
  localparam int SH    = 64;
  localparam int WC    = 300;
  localparam int TO    = 1000;
  localparam int LIMIT = TO + WC + 200;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_wr = 1'b0, req1_wr = 1'b0;
  logic [15:0] req0_addr = 16'h0000, req1_addr = 16'h0000;
  logic [7:0]  req0_wdata = 8'h00, req1_wdata = 8'h00;
  logic        req0_done, req1_done, err, wr_en, rd_en, i2c_start, addr_num;
  logic [7:0]  rd_data, i2c_write_data;
  logic [15:0] byte_addr;
  logic        i2c_end = 1'b0;
  logic [7:0]  i2c_read_data = 8'h00;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_last = 1'b1;
  logic [7:0] m_rd   = 8'h00;
  int         m_lat  = 1;

  // Observations of the last transaction
  int         o_lat, o_slen, o_done_rel, o_done_end, o_done_fall;
  bit         o_d0, o_d1, o_err, o_post, o_unstable, o_to, o_pulse_ok;
  logic       o_wr_en, o_rd_en;
  logic [15:0] o_addr;
  logic [7:0] o_wdata, o_rd, o_rd_next;

  always #5 sys_clk = ~sys_clk;

  i2c_arbiter #(.START_HOLD(SH), .WR_CYCLE(WC), .TIMEOUT(TO), .ADDR_NUM(1'b1)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_wr(req0_wr), .req1_wr(req1_wr),
    .req0_addr(req0_addr), .req1_addr(req1_addr),
    .req0_wdata(req0_wdata), .req1_wdata(req1_wdata),
    .req0_done(req0_done), .req1_done(req1_done),
    .rd_data(rd_data), .err(err),
    .wr_en(wr_en), .rd_en(rd_en), .i2c_start(i2c_start), .addr_num(addr_num),
    .byte_addr(byte_addr), .i2c_write_data(i2c_write_data),
    .i2c_end(i2c_end), .i2c_read_data(i2c_read_data)
  );

  function automatic bit m_pick(input bit v0, input bit v1);
    return (v0 && v1) ? !m_last : v1;
  endfunction

  // Runs one transaction and records observations. mode: 0 = i2c_end never,
  // 1 = pulse 'dly' cycles into WAIT_END, 2 = high across START->WAIT_END,
  // then low, then a second rise.
  task automatic do_txn(input bit v0, input bit v1, input bit w0, input bit w1,
                        input logic [15:0] a0, input logic [15:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] rdat,
                        input int mode, input int dly, input bit drop_early, input bit tail);
    int t, first_t, fall_t, rise_t, done_t;
    bit nxt;
    req0_valid = v0; req1_valid = v1; req0_wr = w0; req1_wr = w1;
    req0_addr = a0; req1_addr = a1; req0_wdata = d0; req1_wdata = d1;
    i2c_read_data = rdat; i2c_end = 1'b0;
    t = 0; first_t = -1; fall_t = -1; rise_t = -1; done_t = -1;
    o_lat = -1; o_slen = 0; o_unstable = 0; o_d0 = 0; o_d1 = 0; o_err = 0; o_post = 0;
    o_wr_en = 1'bx; o_rd_en = 1'bx; o_addr = 16'hxxxx; o_wdata = 8'hxx;
    while (done_t < 0 && t < LIMIT) begin
      @(negedge sys_clk);
      t++;
      if (req0_done || req1_done) begin
        done_t = t; o_d0 = req0_done; o_d1 = req1_done; o_err = err; o_rd = rd_data;
        o_post = wr_en | rd_en | i2c_start;
      end else begin
        if (i2c_start) begin
          if (first_t < 0) begin
            first_t = t; o_lat = t;
            o_wr_en = wr_en; o_rd_en = rd_en; o_addr = byte_addr; o_wdata = i2c_write_data;
            if (drop_early) begin
              req0_valid = 1'b0; req1_valid = 1'b0;
            end
          end
          o_slen++;
        end else if (first_t >= 0 && fall_t < 0) begin
          fall_t = t;
        end
        if (first_t >= 0 && (wr_en !== o_wr_en || rd_en !== o_rd_en ||
                             byte_addr !== o_addr || i2c_write_data !== o_wdata))
          o_unstable = 1;
        nxt = 1'b0;
        if (mode == 1 && fall_t >= 0)
          nxt = (t >= fall_t + dly) && (t < fall_t + dly + 4);
        else if (mode == 2 && first_t >= 0)
          nxt = (t >= first_t + SH - 3 && (fall_t < 0 || t < fall_t + 2)) ||
                (fall_t >= 0 && t >= fall_t + 5 && t < fall_t + 9);
        if (nxt && !i2c_end) rise_t = t;
        i2c_end = nxt;
      end
    end
    i2c_end = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    o_to = (done_t < 0);
    o_done_rel  = done_t - first_t;
    o_done_end  = done_t - rise_t;
    o_done_fall = done_t - fall_t;
    checks++;
    if (o_to) begin
      errors++; $display("FAIL txn_bound: no done within %0d cycles", LIMIT);
    end
    o_pulse_ok = 1; o_rd_next = o_rd;
    if (tail) begin
      @(negedge sys_clk);
      o_pulse_ok = !(req0_done || req1_done || err);
      o_rd_next = rd_data;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; i2c_end = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({req0_done, req1_done, err} !== 3'b000) begin
      errors++; $display("FAIL rst_done: got %b want 000", {req0_done, req1_done, err});
    end
    checks++;
    if ({wr_en, rd_en, i2c_start} !== 3'b000) begin
      errors++; $display("FAIL rst_ctrl: got %b want 000", {wr_en, rd_en, i2c_start});
    end
    checks++;
    if (byte_addr !== 16'h0000 || i2c_write_data !== 8'h00 || rd_data !== 8'h00) begin
      errors++; $display("FAIL rst_data: got %h/%h/%h want 0", byte_addr, i2c_write_data, rd_data);
    end
    checks++;
    if (addr_num !== 1'b1) begin
      errors++; $display("FAIL addr_num: got %b want 1", addr_num);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; i2c_end = 1'b0;
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    m_last = 1'b1; m_rd = 8'h00; m_lat = 1;
  endtask

  task automatic test_alternation();
    bit exp_g;
    logic [7:0] r;
    for (int i = 0; i < 3; i++) begin
      exp_g = (i == 1);
      r = 8'($urandom);
      do_txn(1, 1, 0, 0, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'h00, 8'h00, r, 1, 2, 0, 0);
      checks++;
      if (o_d0 !== !exp_g || o_d1 !== exp_g) begin
        errors++; $display("FAIL alt%0d grant: got d0=%b d1=%b want req%0d", i, o_d0, o_d1, exp_g);
      end
      checks++;
      if (o_lat !== 1) begin
        errors++; $display("FAIL alt%0d latency: got %0d want 1", i, o_lat);
      end
      checks++;
      if (o_rd !== r) begin
        errors++; $display("FAIL alt%0d rd_data: got %h want %h", i, o_rd, r);
      end
      m_last = exp_g; m_rd = r; m_lat = 1;
    end
  endtask

  task automatic test_write();
    do_txn(1, 0, 1, 0, 16'h0010, 16'h0000, 8'hA5, 8'h00, 8'h99, 1, 5, 0, 0);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_en !== 1'b0 || o_addr !== 16'h0010 || o_wdata !== 8'hA5) begin
      errors++; $display("FAIL wr_ctrl: got wr=%b rd=%b a=%h d=%h want 1 0 0010 a5", o_wr_en, o_rd_en, o_addr, o_wdata);
    end
    checks++;
    if (o_slen !== SH) begin
      errors++; $display("FAIL wr_start_len: got %0d want %0d", o_slen, SH);
    end
    checks++;
    if (o_d0 !== 1'b1 || o_d1 !== 1'b0 || o_err !== 1'b0 || o_done_end !== 1) begin
      errors++; $display("FAIL wr_done: got d0=%b d1=%b err=%b dt=%0d want 1 0 0 1", o_d0, o_d1, o_err, o_done_end);
    end
    checks++;
    if (o_rd !== m_rd || o_post !== 1'b0 || o_unstable !== 1'b0) begin
      errors++; $display("FAIL wr_side: got rd=%h post=%b unst=%b want %h 0 0", o_rd, o_post, o_unstable, m_rd);
    end
    m_last = 1'b0; m_lat = WC + 1;
  endtask

  task automatic test_read();
    do_txn(0, 1, 0, 0, 16'h0000, 16'h0123, 8'h00, 8'h00, 8'h3C, 1, 3, 0, 1);
    checks++;
    if (o_lat !== m_lat) begin
      errors++; $display("FAIL wr_wait_gap: got %0d want %0d", o_lat, m_lat);
    end
    checks++;
    if (o_rd_en !== 1'b1 || o_wr_en !== 1'b0 || o_addr !== 16'h0123) begin
      errors++; $display("FAIL rd_ctrl: got rd=%b wr=%b a=%h want 1 0 0123", o_rd_en, o_wr_en, o_addr);
    end
    checks++;
    if (o_d1 !== 1'b1 || o_d0 !== 1'b0 || o_rd !== 8'h3C) begin
      errors++; $display("FAIL rd_done: got d1=%b d0=%b rd=%h want 1 0 3c", o_d1, o_d0, o_rd);
    end
    checks++;
    if (o_pulse_ok !== 1'b1 || o_rd_next !== 8'h3C) begin
      errors++; $display("FAIL rd_pulse: got ok=%b rd=%h want 1 3c", o_pulse_ok, o_rd_next);
    end
    m_last = 1'b1; m_rd = 8'h3C; m_lat = 1;
  endtask

  task automatic test_timeout();
    do_txn(1, 0, 0, 0, 16'h0555, 16'h0000, 8'h00, 8'h00, 8'hEE, 0, 0, 0, 1);
    checks++;
    if (o_d0 !== 1'b1 || o_err !== 1'b1) begin
      errors++; $display("FAIL to_done_err: got d0=%b err=%b want 1 1", o_d0, o_err);
    end
    checks++;
    if (o_done_rel !== TO) begin
      errors++; $display("FAIL to_cycles: got %0d want %0d", o_done_rel, TO);
    end
    checks++;
    if (o_rd !== m_rd || o_post !== 1'b0 || o_pulse_ok !== 1'b1) begin
      errors++; $display("FAIL to_side: got rd=%h post=%b ok=%b want %h 0 1", o_rd, o_post, o_pulse_ok, m_rd);
    end
    m_last = 1'b0; m_lat = 1;
    // Back in IDLE (no busy wait): the next request starts at once
    do_txn(0, 1, 0, 0, 16'h0000, 16'h0777, 8'h00, 8'h00, 8'h5A, 2, 0, 0, 0);
    checks++;
    if (o_lat !== 1) begin
      errors++; $display("FAIL to_idle: got lat %0d want 1", o_lat);
    end
    checks++;
    if (o_d1 !== 1'b1 || o_done_end !== 1 || o_done_fall !== 6 || o_rd !== 8'h5A) begin
      errors++; $display("FAIL preheld_end: got d1=%b de=%0d df=%0d rd=%h want 1 1 6 5a", o_d1, o_done_end, o_done_fall, o_rd);
    end
    m_last = 1'b1; m_rd = 8'h5A; m_lat = 1;
  endtask

  task automatic test_drop_valid();
    do_txn(1, 0, 1, 0, 16'h0042, 16'h0000, 8'h11, 8'h00, 8'h00, 1, 4, 1, 0);
    checks++;
    if (o_d0 !== 1'b1 || o_err !== 1'b0 || o_slen !== SH) begin
      errors++; $display("FAIL drop_valid: got d0=%b err=%b slen=%0d want 1 0 %0d", o_d0, o_err, o_slen, SH);
    end
    m_last = 1'b0; m_lat = WC + 1;
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 16'h0066; i2c_end = 1'b0;
    n = 0;
    while (!i2c_start && n < LIMIT) begin @(negedge sys_clk); n++; end
    while (i2c_start && n < LIMIT) begin @(negedge sys_clk); n++; end
    checks++;
    if (n >= LIMIT) begin
      errors++; $display("FAIL rmid_reach: WAIT_END not reached in %0d cycles", LIMIT);
    end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0; req0_valid = 1'b0;
    @(negedge sys_clk);
    checks++;
    if ({req0_done, req1_done, err, wr_en, rd_en, i2c_start} !== 6'b0 ||
        byte_addr !== 16'h0000 || rd_data !== 8'h00) begin
      errors++; $display("FAIL rmid_outputs: got %b a=%h rd=%h want 0", {req0_done, req1_done, err, wr_en, rd_en, i2c_start}, byte_addr, rd_data);
    end
    sys_rst_n = 1'b1;
    seen = 0;
    i2c_end = 1'b1;
    repeat (4) begin @(negedge sys_clk); if (req0_done || req1_done || err) seen = 1; end
    i2c_end = 1'b0;
    checks++;
    if (seen) begin
      errors++; $display("FAIL rmid_no_done: got a done pulse want none");
    end
    m_last = 1'b1; m_rd = 8'h00; m_lat = 1;
    do_txn(1, 1, 0, 1, 16'h0077, 16'h0088, 8'h00, 8'h22, 8'h77, 1, 1, 0, 0);
    checks++;
    if (o_lat !== 1 || o_d0 !== 1'b1 || o_rd !== 8'h77) begin
      errors++; $display("FAIL rmid_after: got lat=%0d d0=%b rd=%h want 1 1 77", o_lat, o_d0, o_rd);
    end
    m_last = 1'b0; m_rd = 8'h77; m_lat = 1;
  endtask

  task automatic test_random();
    bit v0, v1, w0, w1, g, ewr, to, tl;
    logic [15:0] a0, a1;
    logic [7:0] d0, d1, r, erd;
    int dly, v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom_range(1, 3); v0 = v[0]; v1 = v[1];
      w0 = 1'($urandom); w1 = 1'($urandom);
      a0 = 16'($urandom); a1 = 16'($urandom); d0 = 8'($urandom); d1 = 8'($urandom); r = 8'($urandom);
      to = ($urandom_range(0, 7) == 0); dly = $urandom_range(0, 15); tl = 1'($urandom);
      g = m_pick(v0, v1);
      ewr = g ? w1 : w0;
      erd = (!ewr && !to) ? r : m_rd;
      do_txn(v0, v1, w0, w1, a0, a1, d0, d1, r, to ? 0 : 1, dly, 0, tl);
      checks++;
      if (o_d0 !== !g || o_d1 !== g) begin
        errors++; $display("FAIL rnd%0d grant: got d0=%b d1=%b want req%0d", i, o_d0, o_d1, g);
      end
      checks++;
      if (o_lat !== m_lat) begin
        errors++; $display("FAIL rnd%0d latency: got %0d want %0d", i, o_lat, m_lat);
      end
      checks++;
      if (o_wr_en !== ewr || o_rd_en !== !ewr || o_addr !== (g ? a1 : a0) || o_wdata !== (g ? d1 : d0)) begin
        errors++; $display("FAIL rnd%0d ctrl: got wr=%b rd=%b a=%h d=%h want %b %b %h %h", i, o_wr_en, o_rd_en, o_addr, o_wdata, ewr, !ewr, g ? a1 : a0, g ? d1 : d0);
      end
      checks++;
      if (o_slen !== SH) begin
        errors++; $display("FAIL rnd%0d start_len: got %0d want %0d", i, o_slen, SH);
      end
      checks++;
      if (o_err !== to || o_rd !== erd) begin
        errors++; $display("FAIL rnd%0d result: got err=%b rd=%h want %b %h", i, o_err, o_rd, to, erd);
      end
      checks++;
      if ((to && o_done_rel !== TO) || (!to && o_done_end !== 1)) begin
        errors++; $display("FAIL rnd%0d timing: got rel=%0d end=%0d want %0d", i, o_done_rel, o_done_end, to ? TO : 1);
      end
      checks++;
      if (o_unstable !== 1'b0 || o_post !== 1'b0 || o_pulse_ok !== 1'b1 || o_rd_next !== erd) begin
        errors++; $display("FAIL rnd%0d side: got unst=%b post=%b ok=%b rdn=%h want 0 0 1 %h", i, o_unstable, o_post, o_pulse_ok, o_rd_next, erd);
      end
      m_last = g; m_rd = erd;
      m_lat = (ewr && !to) ? WC + 1 - int'(tl) : 1;
    end
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_write();
    test_read();
    test_timeout();
    test_drop_valid();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_bound: simulation did not finish in time");
    $fatal(1);
  end
endmodule
